seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
Receive side of the seven-segment display interface. Samples a multiplexed, active-low segment bus plus active-low digit selects, and decodes each stable segment pattern back to a BCD digit. Assembles a full frame of NUM_DIGITS digits with a one-cycle valid pulse. Used as a loopback and self-check monitor on the display outputs of the alarm clock.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; range 1..8
STABLE_CYCLES, 4, consecutive identical synchronized samples required to commit a digit; minimum 2
TIMEOUT_CYCLES, 1000000, cycles without a completed frame before stale asserts

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg_in_n  input  7  segment bus, active low; bit0=a ... bit5=f, bit6=g
dig_sel_n  input  NUM_DIGITS  digit selects, active low, one-hot-low when valid
digits_out  output  4*NUM_DIGITS  decoded frame; digit i occupies bits [4i+3:4i]
frame_valid  output  1  one-cycle pulse; digits_out updated in the same cycle
seg_err  output  1  one-cycle pulse when an undecodable pattern is committed
sel_err  output  1  one-cycle pulse on each synchronized sample with more than one select low
stale  output  1  level; no frame completed for TIMEOUT_CYCLES

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - digits_out = all 4'hF.
  - frame_valid, seg_err, sel_err, stale = 0.
  - Internal: committed mask, stability counter and timeout counter cleared.
- Synchronizers: seg_in_n and dig_sel_n each pass through 2-flop synchronizers. All further logic uses the synchronized values.
- Decode table, active low:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111 = blank, code 4'hF.
  - Any other pattern = invalid, code 4'hE.
- Selection:
  - Exactly one dig_sel_n bit low: the sample is valid for digit i.
  - All selects high: no capture; the stability counter clears.
  - More than one low: no capture, the counter clears, sel_err pulses.
- Stability:
  - The counter increments while the synchronized sample (seg pattern plus selected index) equals the previous sample.
  - Any change reloads the counter to 1.
  - When the counter reaches STABLE_CYCLES, the decoded code is committed to a holding register for digit i, and mask bit i is set.
  - Commit happens once per selection window: the counter saturates and no re-commit occurs until the sample changes.
  - Committing an invalid code pulses seg_err in the commit cycle.
  - A digit re-committed before frame completion overwrites its holding value; this is not an error.
- Frame:
  - In the cycle after the mask becomes all ones, the holding registers copy to digits_out, frame_valid pulses, and the mask clears.
  - A commit to the last missing digit counts toward that frame.
  - A commit occurring in the frame_valid cycle itself sets its mask bit for the next frame.
- Latency: from a stable pattern appearing at the pins to the commit is 2 + STABLE_CYCLES cycles; frame_valid follows 1 cycle later.
- Timeout:
  - The timeout counter clears on each frame_valid and saturates at TIMEOUT_CYCLES.
  - stale = 1 while the counter is saturated; it drops in the frame_valid cycle.
- Reset mid-frame: partial holding data and the mask are discarded, and digits_out returns to blank.

Optional Feature:
SEG7_ALT_GLYPH_EN:
- Defined: these alternate glyphs also decode and never raise seg_err:
  - 6 without segment a, 0000011 -> 6.
  - 7 with segment f, 1011000 -> 7.
  - 9 without segment d, 0011000 -> 9.
- Undefined: those three patterns are invalid (4'hE, seg_err on commit).

Test Plan:
1. Reset, then drive NUM_DIGITS=4 with a scan of 1,2,3,4 held 8 cycles per digit, STABLE_CYCLES=4 -> one frame_valid pulse, digits_out=16'h4321, seg_err=0.
2. During a frame, hold digit 2 at pattern 0001000 -> seg_err pulses once at commit; the next frame shows digit 2 = 4'hE.
3. Drive dig_sel_n=4'b1100 for 3 cycles -> sel_err pulses 3 times, no commit, mask unchanged; a clean scan afterwards yields a correct frame.
4. Toggle the segments every 3 cycles with STABLE_CYCLES=4 -> no commit and no frame_valid; with TIMEOUT_CYCLES=100, stale=1 at cycle 100 and it clears on the first good frame.
5. Assert rst_n low after digits 0 and 1 have committed -> digits_out=16'hFFFF; a fresh full scan afterwards yields exactly one frame with the new data.
6. Drive pattern 0000011 on digit 0 -> with SEG7_ALT_GLYPH_EN defined, digit 0 = 6 and seg_err=0; with it undefined, digit 0 = 4'hE and seg_err pulses.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bus between a multiplexed seven-segment driver and the scan-capture monitor.
// The master drives the segment/select pins; the slave returns decoded frames and error flags.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in_n;
    logic [NUM_DIGITS-1:0]   dig_sel_n;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic                    frame_valid;
    logic                    seg_err;
    logic                    sel_err;
    logic                    stale;

    modport master (
        output seg_in_n, dig_sel_n,
        input  digits_out, frame_valid, seg_err, sel_err, stale
    );

    modport slave (
        input  seg_in_n, dig_sel_n,
        output digits_out, frame_valid, seg_err, sel_err, stale
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed active-low seven-segment bus and rebuilds the displayed BCD frame.
// Optional macro SEG7_ALT_GLYPH_EN accepts alternate glyphs for 6, 7 and 9.
module seg7_scan_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] STAB_PRE = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    function automatic logic [3:0] decode(input logic [6:0] p);
        logic [3:0] c;
        case (p)
            7'b1000000: c = 4'd0;
            7'b1111001: c = 4'd1;
            7'b0100100: c = 4'd2;
            7'b0110000: c = 4'd3;
            7'b0011001: c = 4'd4;
            7'b0010010: c = 4'd5;
            7'b0000010: c = 4'd6;
            7'b1111000: c = 4'd7;
            7'b0000000: c = 4'd8;
            7'b0010000: c = 4'd9;
            7'b1111111: c = 4'hF;
`ifdef SEG7_ALT_GLYPH_EN
            7'b0000011: c = 4'd6;
            7'b1011000: c = 4'd7;
            7'b0011000: c = 4'd9;
`endif
            default:    c = 4'hE;
        endcase
        return c;
    endfunction

    logic [6:0]              seg_s1, seg_s2, seg_prev;
    logic [NUM_DIGITS-1:0]   sel_s1, sel_s2, sel_prev;
    logic                    prev_ok;
    logic [CW-1:0]           stab_cnt, stab_next;
    logic [NUM_DIGITS-1:0]   sel_low, sel_low_m1, mask, mask_next;
    logic [4*NUM_DIGITS-1:0] hold_q, digits_q;
    logic [TW-1:0]           tmo_cnt;
    logic [IW-1:0]           idx;
    logic [3:0]              code;
    logic                    one_low, multi_low, same, commit, frame_fire;
    logic                    frame_q, seg_err_q, sel_err_q;

    // Idle pins (segments dark, no select) are the reset value of the synchronizers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            sel_s1 <= '1;
            sel_s2 <= '1;
        end else begin
            seg_s1 <= bus.seg_in_n;
            seg_s2 <= seg_s1;
            sel_s1 <= bus.dig_sel_n;
            sel_s2 <= sel_s1;
        end
    end

    always_comb begin
        sel_low    = ~sel_s2;
        sel_low_m1 = sel_low - NUM_DIGITS'(1);
        multi_low  = (sel_low & sel_low_m1) != '0;
        one_low    = (sel_low != '0) && !multi_low;
        idx        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_low[i]) idx = IW'(i);
        end
        code = decode(seg_s2);
        same = prev_ok && (seg_s2 == seg_prev) && (sel_s2 == sel_prev);

        stab_next = stab_cnt;
        if (!one_low)
            stab_next = '0;
        else if (!same)
            stab_next = CW'(1);
        else if (stab_cnt != STAB_MAX)
            stab_next = stab_cnt + CW'(1);

        // Commit only on the transition into saturation, once per selection window.
        commit     = one_low && same && (stab_cnt == STAB_PRE);
        frame_fire = &mask;

        mask_next = frame_fire ? '0 : mask;
        if (commit) mask_next[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_prev  <= '1;
            sel_prev  <= '1;
            prev_ok   <= 1'b0;
            stab_cnt  <= '0;
            mask      <= '0;
            hold_q    <= '1;
            digits_q  <= '1;
            frame_q   <= 1'b0;
            seg_err_q <= 1'b0;
            sel_err_q <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            seg_prev  <= seg_s2;
            sel_prev  <= sel_s2;
            prev_ok   <= one_low;
            stab_cnt  <= stab_next;
            mask      <= mask_next;
            frame_q   <= frame_fire;
            seg_err_q <= commit && (code == 4'hE);
            sel_err_q <= multi_low;
            if (frame_fire) digits_q <= hold_q;
            if (commit) hold_q[4*idx +: 4] <= code;
            if (frame_fire)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.frame_valid = frame_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.stale       = (tmo_cnt == TMO_MAX);
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: run-length reference model checked every cycle,
// plus literal frame/pulse expectations per scenario.
module tb_seg7_scan_capture;
    localparam int N = 4;
    localparam int S = 4;
    localparam int T = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_capture #(
        .NUM_DIGITS(N), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic logic [3:0] model_code(input logic [6:0] p);
        if (p == 7'b1111111) return 4'hF;
        for (int d = 0; d < 10; d++)
            if (glyph[d] == p) return 4'(d);
`ifdef SEG7_ALT_GLYPH_EN
        if (p == 7'b0000011) return 4'd6;
        if (p == 7'b1011000) return 4'd7;
        if (p == 7'b0011000) return 4'd9;
`endif
        return 4'hE;
    endfunction

    // Reference model: a digit commits when the synchronized sample (pins two edges back)
    // has been the same valid selection for exactly S consecutive samples.
    typedef struct packed { logic [6:0] seg; logic [N-1:0] sel; } smp_t;
    smp_t       hq[$];
    smp_t       cur;
    logic [3:0] m_hold [N];
    logic [N-1:0]   m_mask;
    logic [4*N-1:0] m_digits;
    logic e_fv, e_se, e_le, e_stale;
    int   edge_n = 0, last_evt = 0, j, run, lows, dsel;
    int   fv_cnt = 0, se_cnt = 0, le_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (!rst_n) begin
                hq.delete();
                repeat (S + 4) hq.push_back(smp_t'{7'h7F, {N{1'b1}}});
                for (int d = 0; d < N; d++) m_hold[d] = 4'hF;
                m_mask   = '0;
                m_digits = '1;
                e_fv = 1'b0; e_se = 1'b0; e_le = 1'b0;
                last_evt = edge_n;
            end else begin
                hq.push_back(smp_t'{bus.seg_in_n, bus.dig_sel_n});
                if (hq.size() > S + 4) void'(hq.pop_front());
                j    = hq.size() - 3;
                cur  = hq[j];
                lows = $countones(~cur.sel);
                run  = 0;
                if (lows == 1) begin
                    for (int i = j; i >= 0; i--) begin
                        if (hq[i] == cur) run++;
                        else break;
                    end
                end
                e_fv = (m_mask == {N{1'b1}});
                if (e_fv) begin
                    for (int d = 0; d < N; d++) m_digits[4*d +: 4] = m_hold[d];
                    m_mask   = '0;
                    last_evt = edge_n;
                end
                e_se = 1'b0;
                if (run == S) begin
                    dsel = 0;
                    for (int d = 0; d < N; d++) if (!cur.sel[d]) dsel = d;
                    m_hold[dsel] = model_code(cur.seg);
                    m_mask[dsel] = 1'b1;
                    e_se = (model_code(cur.seg) == 4'hE);
                end
                e_le = (lows > 1);
            end
            e_stale = (edge_n - last_evt) >= T;
            #1;
            check("digits_out", 32'(bus.digits_out), 32'(m_digits));
            check("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
            check("seg_err", 32'(bus.seg_err), 32'(e_se));
            check("sel_err", 32'(bus.sel_err), 32'(e_le));
            check("stale", 32'(bus.stale), 32'(e_stale));
            fv_cnt += int'(bus.frame_valid);
            se_cnt += int'(bus.seg_err);
            le_cnt += int'(bus.sel_err);
        end
    end

    task automatic hold_pins(input logic [6:0] seg, input logic [N-1:0] sel, input int n);
        bus.seg_in_n  = seg;
        bus.dig_sel_n = sel;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_digit(input logic [6:0] seg, input int d, input int n);
        logic [N-1:0] one;
        one = N'(1) << d;
        hold_pins(seg, ~one, n);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        hold_digit(p0, 0, 8);
        hold_digit(p1, 1, 8);
        hold_digit(p2, 2, 8);
        hold_digit(p3, 3, 8);
        hold_pins(7'h7F, '1, 12);
    endtask

    int f0, s0, l0;

    initial begin
        bus.seg_in_n  = 7'h7F;
        bus.dig_sel_n = '1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(bus.digits_out), 32'h0000FFFF);
        check("rst_fv", 32'(bus.frame_valid), 32'd0);
        check("rst_stale", 32'(bus.stale), 32'd0);
        rst_n = 1'b1;
        hold_pins(7'h7F, '1, 4);

        // basic frame 1,2,3,4
        f0 = fv_cnt; s0 = se_cnt;
        scan(glyph[1], glyph[2], glyph[3], glyph[4]);
        check("t1_frames", 32'(fv_cnt - f0), 32'd1);
        check("t1_digits", 32'(bus.digits_out), 32'h4321);
        check("t1_seg_err", 32'(se_cnt - s0), 32'd0);

        // invalid pattern held 8 cycles commits (and errors) once
        f0 = fv_cnt; s0 = se_cnt;
        scan(glyph[1], glyph[2], 7'b0001000, glyph[4]);
        check("t2_seg_err", 32'(se_cnt - s0), 32'd1);
        check("t2_digits", 32'(bus.digits_out), 32'h4E21);
        check("t2_frames", 32'(fv_cnt - f0), 32'd1);

        // multi-select in mid-frame: errors, no capture, partial mask survives
        f0 = fv_cnt; l0 = le_cnt;
        hold_digit(glyph[5], 0, 8);
        hold_digit(glyph[6], 1, 8);
        hold_pins(glyph[9], 4'b1100, 3);
        hold_pins(7'h7F, '1, 8);
        check("t3_sel_err", 32'(le_cnt - l0), 32'd3);
        check("t3_no_frame", 32'(fv_cnt - f0), 32'd0);
        hold_digit(glyph[7], 2, 8);
        hold_digit(glyph[8], 3, 8);
        hold_pins(7'h7F, '1, 12);
        check("t3_frames", 32'(fv_cnt - f0), 32'd1);
        check("t3_digits", 32'(bus.digits_out), 32'h8765);

        // segments never stable for S samples -> no commit, stale asserts
        f0 = fv_cnt; s0 = se_cnt;
        for (int k = 0; k < 40; k++)
            hold_digit((k % 2 == 0) ? glyph[8] : glyph[0], 0, 3);
        hold_pins(7'h7F, '1, 4);
        check("t4_no_frame", 32'(fv_cnt - f0), 32'd0);
        check("t4_stale", 32'(bus.stale), 32'd1);
        check("t4_no_seg_err", 32'(se_cnt - s0), 32'd0);
        scan(glyph[1], glyph[2], glyph[3], glyph[4]);
        check("t4_stale_clr", 32'(bus.stale), 32'd0);
        check("t4_digits", 32'(bus.digits_out), 32'h4321);

        // reset after two digits committed discards the partial frame
        hold_digit(glyph[5], 0, 8);
        hold_digit(glyph[6], 1, 8);
        hold_pins(7'h7F, '1, 8);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_digits", 32'(bus.digits_out), 32'h0000FFFF);
        rst_n = 1'b1;
        f0 = fv_cnt;
        scan(glyph[9], glyph[8], glyph[7], glyph[0]);
        check("t5_frames", 32'(fv_cnt - f0), 32'd1);
        check("t5_digits", 32'(bus.digits_out), 32'h0789);

        // alternate 6 glyph on digit 0
        f0 = fv_cnt; s0 = se_cnt;
        scan(7'b0000011, glyph[2], glyph[3], glyph[4]);
        check("t6_frames", 32'(fv_cnt - f0), 32'd1);
`ifdef SEG7_ALT_GLYPH_EN
        check("t6_digits", 32'(bus.digits_out), 32'h4326);
        check("t6_seg_err", 32'(se_cnt - s0), 32'd0);
`else
        check("t6_digits", 32'(bus.digits_out), 32'h432E);
        check("t6_seg_err", 32'(se_cnt - s0), 32'd1);
`endif

        hold_pins(7'h7F, '1, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
